// File: rtl/gpio_status_seq_checker.sv
// Checkpoint sequence monitor: synchronises and debounces a firmware status
// nibble, then checks it walks through expected_seq within a cycle budget.
module gpio_status_seq_checker #(
    parameter int unsigned STATUS_W       = 4,
    parameter int unsigned NUM_STEPS      = 3,
    parameter int unsigned STABLE_CYCLES  = 2,
    parameter int unsigned SYNC_STAGES    = 2,
    parameter int unsigned TIMEOUT_CYCLES = 200000,
    parameter int unsigned CNT_W          = 18,
    parameter int unsigned STRICT         = 1,
    localparam int unsigned IDX_W         = $clog2(NUM_STEPS + 1)
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          start,
    input  logic [STATUS_W-1:0]           status_in,
    input  logic [NUM_STEPS*STATUS_W-1:0] expected_seq,
    output logic                          busy,
    output logic                          step_hit,
    output logic [IDX_W-1:0]              step_idx,
    output logic                          pass,
    output logic                          fail_timeout,
    output logic                          fail_order,
    output logic [CNT_W-1:0]              elapsed
);

    localparam int unsigned STB_W = $clog2(STABLE_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, RUN, PASS, FAIL} state_e;

    // Synchroniser chain
    logic [STATUS_W-1:0] sync_q [SYNC_STAGES];

    // Filter state
    logic [STATUS_W-1:0] cand_q, cand_d;
    logic [STB_W-1:0]    cnt_q, cnt_d;
    logic [STATUS_W-1:0] filt_q, filt_d;
    logic                acc_q, acc_d;
    logic [STATUS_W-1:0] samp;

    // Checker state
    state_e              state_q, state_d;
    logic [IDX_W-1:0]    step_idx_q, step_idx_d;
    logic                step_hit_q, step_hit_d;
    logic                busy_q, busy_d;
    logic                pass_q, pass_d;
    logic                fail_timeout_q, fail_timeout_d;
    logic                fail_order_q, fail_order_d;
    logic [CNT_W-1:0]    elapsed_q, elapsed_d;
    logic                seen_q, seen_d;
    logic [STATUS_W-1:0] ign_q, ign_d;
    logic [STATUS_W-1:0] cur_code, prv_code;
    logic                unexpected;

    // Shift the pad value through the synchroniser flops
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < int'(SYNC_STAGES); i++) sync_q[i] <= '0;
        end else begin
            sync_q[0] <= status_in;
            for (int i = 1; i < int'(SYNC_STAGES); i++) sync_q[i] <= sync_q[i-1];
        end
    end

    assign samp = sync_q[SYNC_STAGES-1];

    // Stability filter: one acceptance pulse per run of STABLE_CYCLES equal samples
    always_comb begin
        cand_d = cand_q;
        cnt_d  = cnt_q;
        filt_d = filt_q;
        acc_d  = 1'b0;
        if (samp != cand_q) begin
            cand_d = samp;
            cnt_d  = STB_W'(1);
        end else if (cnt_q < STB_W'(STABLE_CYCLES)) begin
            cnt_d = cnt_q + STB_W'(1);
        end
        if ((cnt_d == STB_W'(STABLE_CYCLES)) &&
            ((samp != cand_q) || (cnt_q != STB_W'(STABLE_CYCLES)))) begin
            acc_d  = 1'b1;
            filt_d = samp;
        end
        // Arming forces the value currently on the pads to be re-accepted
        if (start) begin
            cnt_d = '0;
            acc_d = 1'b0;
        end
    end

    // Filter registers
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cand_q <= '0;
            cnt_q  <= '0;
            filt_q <= '0;
            acc_q  <= 1'b0;
        end else begin
            cand_q <= cand_d;
            cnt_q  <= cnt_d;
            filt_q <= filt_d;
            acc_q  <= acc_d;
        end
    end

    // Current and previous checkpoint codes selected by step_idx
    always_comb begin
        cur_code = '0;
        prv_code = '0;
        for (int i = 0; i < int'(NUM_STEPS); i++) begin
            if (step_idx_q == IDX_W'(i))     cur_code = expected_seq[i*STATUS_W +: STATUS_W];
            if (step_idx_q == IDX_W'(i + 1)) prv_code = expected_seq[i*STATUS_W +: STATUS_W];
        end
    end

    // Checker FSM next-state and outputs
    always_comb begin
        state_d        = state_q;
        step_idx_d     = step_idx_q;
        step_hit_d     = 1'b0;
        pass_d         = pass_q;
        fail_timeout_d = fail_timeout_q;
        fail_order_d   = fail_order_q;
        elapsed_d      = elapsed_q;
        seen_d         = seen_q;
        ign_d          = ign_q;
        unexpected     = 1'b0;
        if (start) begin
            state_d        = RUN;
            step_idx_d     = '0;
            pass_d         = 1'b0;
            fail_timeout_d = 1'b0;
            fail_order_d   = 1'b0;
            elapsed_d      = '0;
            seen_d         = 1'b0;
            ign_d          = '0;
        end else begin
            case (state_q)
                RUN: begin
                    elapsed_d = elapsed_q + CNT_W'(1);
                    if (acc_q) begin
                        seen_d = 1'b1;
                        if (filt_q == cur_code) begin
                            step_hit_d = 1'b1;
                            step_idx_d = step_idx_q + IDX_W'(1);
                            if (step_idx_q == IDX_W'(NUM_STEPS - 1)) begin
                                state_d = PASS;
                                pass_d  = 1'b1;
                            end
                        end else if (step_idx_q == '0) begin
                            // Value already present at arm time is tolerated until it changes
                            if (!seen_q) ign_d = filt_q;
                            else if (filt_q != ign_q) unexpected = 1'b1;
                        end else if (filt_q != prv_code) begin
                            unexpected = 1'b1;
                        end
                    end
                    if (unexpected && (STRICT != 0)) begin
                        state_d      = FAIL;
                        fail_order_d = 1'b1;
                    end else if ((state_d == RUN) &&
                                 (elapsed_q >= CNT_W'(TIMEOUT_CYCLES - 1))) begin
                        state_d        = FAIL;
                        fail_timeout_d = 1'b1;
                        elapsed_d      = elapsed_q;
                    end
                end
                default: ;
            endcase
        end
        busy_d = (state_d == RUN);
    end

    // Checker FSM registers
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q        <= IDLE;
            step_idx_q     <= '0;
            step_hit_q     <= 1'b0;
            busy_q         <= 1'b0;
            pass_q         <= 1'b0;
            fail_timeout_q <= 1'b0;
            fail_order_q   <= 1'b0;
            elapsed_q      <= '0;
            seen_q         <= 1'b0;
            ign_q          <= '0;
        end else begin
            state_q        <= state_d;
            step_idx_q     <= step_idx_d;
            step_hit_q     <= step_hit_d;
            busy_q         <= busy_d;
            pass_q         <= pass_d;
            fail_timeout_q <= fail_timeout_d;
            fail_order_q   <= fail_order_d;
            elapsed_q      <= elapsed_d;
            seen_q         <= seen_d;
            ign_q          <= ign_d;
        end
    end

    assign busy         = busy_q;
    assign step_hit     = step_hit_q;
    assign step_idx     = step_idx_q;
    assign pass         = pass_q;
    assign fail_timeout = fail_timeout_q;
    assign fail_order   = fail_order_q;
    assign elapsed      = elapsed_q;

endmodule

// File: tb/tb_gpio_status_seq_checker.sv
// Directed bench for gpio_status_seq_checker: default, short-timeout and
// non-strict instances share stimulus; each test checks the relevant one.
module tb_gpio_status_seq_checker;

    logic        clock = 1'b0;
    logic        reset;
    logic        start;
    logic [3:0]  status_in;
    logic [11:0] expected_seq;

    logic        d_busy, d_hit, d_pass, d_fto, d_ford;
    logic [1:0]  d_idx;
    logic [17:0] d_el;
    logic        t_busy, t_hit, t_pass, t_fto, t_ford;
    logic [1:0]  t_idx;
    logic [17:0] t_el;
    logic        n_busy, n_hit, n_pass, n_fto, n_ford;
    logic [1:0]  n_idx;
    logic [17:0] n_el;

    int checks = 0;
    int errors = 0;
    int hits;
    int first;

    always #5 clock = ~clock;

    gpio_status_seq_checker u_dut (
        .clock(clock), .reset(reset), .start(start), .status_in(status_in),
        .expected_seq(expected_seq), .busy(d_busy), .step_hit(d_hit),
        .step_idx(d_idx), .pass(d_pass), .fail_timeout(d_fto),
        .fail_order(d_ford), .elapsed(d_el)
    );

    gpio_status_seq_checker #(.TIMEOUT_CYCLES(100)) u_to (
        .clock(clock), .reset(reset), .start(start), .status_in(status_in),
        .expected_seq(expected_seq), .busy(t_busy), .step_hit(t_hit),
        .step_idx(t_idx), .pass(t_pass), .fail_timeout(t_fto),
        .fail_order(t_ford), .elapsed(t_el)
    );

    gpio_status_seq_checker #(.STRICT(0)) u_ns (
        .clock(clock), .reset(reset), .start(start), .status_in(status_in),
        .expected_seq(expected_seq), .busy(n_busy), .step_hit(n_hit),
        .step_idx(n_idx), .pass(n_pass), .fail_timeout(n_fto),
        .fail_order(n_ford), .elapsed(n_el)
    );

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic do_start();
        start = 1'b1;
        tick(1);
        start = 1'b0;
    endtask

    // Drive a value for n cycles, counting step_hit pulses of the default instance
    task automatic hold(input logic [3:0] v, input int n);
        status_in = v;
        hits  = 0;
        first = 0;
        for (int k = 1; k <= n; k++) begin
            tick(1);
            if (d_hit === 1'b1) begin
                hits++;
                if (first == 0) first = k;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        start = 1'b0;
        status_in = 4'h0;
        expected_seq = 12'hCA5;
        tick(3);
        checks++;
        if ({d_busy, d_hit, d_idx, d_pass, d_fto, d_ford, d_el} !== 25'd0) begin
            errors++;
            $display("FAIL reset_outputs: got %0h expected 0", {d_busy, d_hit, d_idx, d_pass, d_fto, d_ford, d_el});
        end
        reset = 1'b0;
        tick(4);
        checks++;
        if ({d_busy, d_idx, d_el} !== 21'd0) begin
            errors++;
            $display("FAIL idle_after_reset: got %0h expected 0", {d_busy, d_idx, d_el});
        end
    endtask

    task automatic test_sequence();
        do_start();
        checks++;
        if (d_busy !== 1'b1 || d_el !== 18'd0) begin
            errors++;
            $display("FAIL arm: busy=%b elapsed=%0d expected busy=1 elapsed=0", d_busy, d_el);
        end
        hold(4'h5, 50);
        checks++;
        if (hits != 1 || first != 5 || d_idx !== 2'd1) begin
            errors++;
            $display("FAIL step1: hits=%0d at=%0d idx=%0d expected 1 at 5 idx 1", hits, first, d_idx);
        end
        hold(4'hA, 50);
        checks++;
        if (hits != 1 || first != 5 || d_idx !== 2'd2) begin
            errors++;
            $display("FAIL step2: hits=%0d at=%0d idx=%0d expected 1 at 5 idx 2", hits, first, d_idx);
        end
        hold(4'hC, 50);
        checks++;
        if (hits != 1 || first != 5 || d_idx !== 2'd3) begin
            errors++;
            $display("FAIL step3: hits=%0d at=%0d idx=%0d expected 1 at 5 idx 3", hits, first, d_idx);
        end
        checks++;
        if ({d_pass, d_busy, d_fto, d_ford} !== 4'b1000 || d_el !== 18'd105) begin
            errors++;
            $display("FAIL pass_state: pass/busy/fto/ford=%b elapsed=%0d expected 1000 elapsed=105",
                     {d_pass, d_busy, d_fto, d_ford}, d_el);
        end
    endtask

    task automatic test_timeout();
        do_start();
        status_in = 4'h5;
        tick(99);
        checks++;
        if (t_busy !== 1'b1 || t_fto !== 1'b0 || t_el !== 18'd99) begin
            errors++;
            $display("FAIL pre_timeout: busy=%b fto=%b elapsed=%0d expected 1 0 99", t_busy, t_fto, t_el);
        end
        tick(1);
        checks++;
        if (t_fto !== 1'b1 || t_busy !== 1'b0 || t_el !== 18'd99 || t_idx !== 2'd1 || t_pass !== 1'b0) begin
            errors++;
            $display("FAIL timeout: fto=%b busy=%b elapsed=%0d idx=%0d pass=%b expected 1 0 99 1 0",
                     t_fto, t_busy, t_el, t_idx, t_pass);
        end
        tick(10);
        checks++;
        if (t_el !== 18'd99 || t_fto !== 1'b1) begin
            errors++;
            $display("FAIL timeout_frozen: elapsed=%0d fto=%b expected 99 1", t_el, t_fto);
        end
    endtask

    task automatic test_order();
        do_start();
        hold(4'h5, 20);
        checks++;
        if (d_idx !== 2'd1 || n_idx !== 2'd1) begin
            errors++;
            $display("FAIL order_step1: idx=%0d ns_idx=%0d expected 1 1", d_idx, n_idx);
        end
        status_in = 4'h3;
        tick(4);
        checks++;
        if (d_ford !== 1'b0 || d_busy !== 1'b1) begin
            errors++;
            $display("FAIL order_early: ford=%b busy=%b expected 0 1", d_ford, d_busy);
        end
        tick(1);
        checks++;
        if (d_ford !== 1'b1 || d_busy !== 1'b0 || d_pass !== 1'b0) begin
            errors++;
            $display("FAIL order_fail: ford=%b busy=%b pass=%b expected 1 0 0", d_ford, d_busy, d_pass);
        end
        checks++;
        if (n_ford !== 1'b0 || n_busy !== 1'b1) begin
            errors++;
            $display("FAIL nonstrict_tolerates: ford=%b busy=%b expected 0 1", n_ford, n_busy);
        end
        hold(4'hA, 20);
        hold(4'hC, 20);
        checks++;
        if (n_pass !== 1'b1 || n_idx !== 2'd3 || n_ford !== 1'b0) begin
            errors++;
            $display("FAIL nonstrict_pass: pass=%b idx=%0d ford=%b expected 1 3 0", n_pass, n_idx, n_ford);
        end
        checks++;
        if (d_ford !== 1'b1 || d_idx !== 2'd1) begin
            errors++;
            $display("FAIL order_sticky: ford=%b idx=%0d expected 1 1", d_ford, d_idx);
        end
    endtask

    task automatic test_glitch();
        do_start();
        hold(4'h5, 20);
        checks++;
        if (hits != 1 || d_idx !== 2'd1) begin
            errors++;
            $display("FAIL glitch_setup: hits=%0d idx=%0d expected 1 1", hits, d_idx);
        end
        status_in = 4'hA;
        tick(1);
        hold(4'h5, 20);
        checks++;
        if (hits != 0 || d_idx !== 2'd1 || d_ford !== 1'b0 || d_busy !== 1'b1) begin
            errors++;
            $display("FAIL glitch: hits=%0d idx=%0d ford=%b busy=%b expected 0 1 0 1", hits, d_idx, d_ford, d_busy);
        end
    endtask

    task automatic test_reset_midrun();
        do_start();
        hold(4'h5, 20);
        hold(4'hA, 20);
        checks++;
        if (d_idx !== 2'd2) begin
            errors++;
            $display("FAIL midrun_step2: idx=%0d expected 2", d_idx);
        end
        reset = 1'b1;
        #1;
        checks++;
        if ({d_busy, d_hit, d_idx, d_pass, d_fto, d_ford, d_el} !== 25'd0) begin
            errors++;
            $display("FAIL async_reset: got %0h expected 0", {d_busy, d_hit, d_idx, d_pass, d_fto, d_ford, d_el});
        end
        tick(1);
        reset = 1'b0;
        tick(1);
        checks++;
        if ({d_busy, d_idx, d_el} !== 21'd0) begin
            errors++;
            $display("FAIL post_reset_idle: got %0h expected 0", {d_busy, d_idx, d_el});
        end
        do_start();
        hold(4'h5, 20);
        hold(4'hA, 20);
        hold(4'hC, 20);
        checks++;
        if (d_pass !== 1'b1 || d_idx !== 2'd3 || d_busy !== 1'b0) begin
            errors++;
            $display("FAIL rerun_pass: pass=%b idx=%0d busy=%b expected 1 3 0", d_pass, d_idx, d_busy);
        end
    endtask

    task automatic test_back_to_back();
        do_start();
        hold(4'h5, 20);
        checks++;
        if (d_idx !== 2'd1 || d_el !== 18'd20) begin
            errors++;
            $display("FAIL restart_setup: idx=%0d elapsed=%0d expected 1 20", d_idx, d_el);
        end
        do_start();
        checks++;
        if (d_idx !== 2'd0 || d_el !== 18'd0 || d_busy !== 1'b1 || d_hit !== 1'b0) begin
            errors++;
            $display("FAIL restart: idx=%0d elapsed=%0d busy=%b hit=%b expected 0 0 1 0", d_idx, d_el, d_busy, d_hit);
        end
        hold(4'h5, 20);
        checks++;
        if (hits != 1 || d_idx !== 2'd1) begin
            errors++;
            $display("FAIL restart_step1: hits=%0d idx=%0d expected 1 1", hits, d_idx);
        end
        hold(4'hA, 20);
        hold(4'hC, 20);
        checks++;
        if (d_pass !== 1'b1 || d_idx !== 2'd3 || d_el !== 18'd45) begin
            errors++;
            $display("FAIL restart_pass: pass=%b idx=%0d elapsed=%0d expected 1 3 45", d_pass, d_idx, d_el);
        end
    endtask

    initial begin
        test_reset();
        test_sequence();
        test_timeout();
        test_order();
        test_glitch();
        test_reset_midrun();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
